// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer in ID: load-use stall, stack-pop stall and redirect flush control.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W       = 5,
    parameter int POP_STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic                  id_src1_vld,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_vld,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_is_load,
    input  logic                  pc_redirect,
    input  logic                  pop_req,
    output logic                  data_hazard,
    output logic                  PC_hazard,
    output logic                  pop_haz,
    output logic                  flush_ifid,
    output logic                  bubble_idex,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    localparam int MAX_CYC = (POP_STALL_CYCLES > FLUSH_CYCLES) ? POP_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FLUSH  = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_POP    = CNT_W'(POP_STALL_CYCLES - 1);
    localparam bit               POP_MULTI  = (POP_STALL_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             load_use_s;
    logic             src1_hit_s;
    logic             src2_hit_s;

    // Load-use detection; register 0 is hard-wired and never creates a hazard.
    always_comb begin
        src1_hit_s = id_src1_vld && (id_src1 == ex_dst);
        src2_hit_s = id_src2_vld && (id_src2 == ex_dst);
        load_use_s = ex_is_load && (ex_dst != {REG_ADDR_W{1'b0}}) && (src1_hit_s || src2_hit_s);
    end

    // Same-cycle stall outputs and next-state/counter selection.
    always_comb begin
        data_hazard = 1'b0;
        PC_hazard   = 1'b0;
        pop_haz     = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        busy        = 1'b0;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (rst) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    flush_ifid  = pc_redirect;
                    bubble_idex = pc_redirect || load_use_s;
                    data_hazard = load_use_s && !pc_redirect;
                    pop_haz     = pop_req && !load_use_s && !pc_redirect;
                    if (pc_redirect) begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = CNT_FLUSH;
                    end else if (pop_haz && POP_MULTI) begin
                        state_nxt_s = ST_POP;
                        cnt_nxt_s   = CNT_POP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                ST_POP: begin
                    busy        = 1'b1;
                    bubble_idex = 1'b1;
                    if (pc_redirect) begin
                        // Redirect kills the pop outright: pop_haz drops this cycle.
                        flush_ifid  = 1'b1;
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = CNT_FLUSH;
                    end else begin
                        pop_haz = 1'b1;
                        if (cnt_r <= CNT_ONE) begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = CNT_ZERO;
                        end else begin
                            state_nxt_s = ST_POP;
                            cnt_nxt_s   = cnt_r - CNT_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    busy        = 1'b1;
                    PC_hazard   = 1'b1;
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (pc_redirect) begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = CNT_FLUSH;
                    end else if (cnt_r <= CNT_ONE) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to IDLE without asserting anything.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    logic        stall_any_s;

    assign stall_any_s = data_hazard || pop_haz || PC_hazard;

    // Saturating count of cycles in which any stall is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_any_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random stimulus
// against a behavioural model that tracks remaining pop/flush cycles.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int PC = 2;
    localparam int FC = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] id_src1 = '0;
    logic          id_src1_vld = 1'b0;
    logic [AW-1:0] id_src2 = '0;
    logic          id_src2_vld = 1'b0;
    logic [AW-1:0] ex_dst = '0;
    logic          ex_is_load = 1'b0;
    logic          pc_redirect = 1'b0;
    logic          pop_req = 1'b0;
    logic          data_hazard, PC_hazard, pop_haz, flush_ifid, bubble_idex, busy;
    logic [15:0]   stall_cnt;
    logic [5:0]    obs;

    int total = 0;
    int bad   = 0;

    // Model state: remaining pop / flush cycles and the stall count.
    int pop_left_m   = 0;
    int flush_left_m = 0;
    int perf_m       = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .POP_STALL_CYCLES(PC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_vld(id_src1_vld),
        .id_src2(id_src2), .id_src2_vld(id_src2_vld),
        .ex_dst(ex_dst), .ex_is_load(ex_is_load),
        .pc_redirect(pc_redirect), .pop_req(pop_req),
        .data_hazard(data_hazard), .PC_hazard(PC_hazard), .pop_haz(pop_haz),
        .flush_ifid(flush_ifid), .bubble_idex(bubble_idex), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    assign obs = {data_hazard, PC_hazard, pop_haz, flush_ifid, bubble_idex, busy};

    always #5 clk = ~clk;

    function automatic bit lu();
        return ex_is_load && (ex_dst != 0) &&
               ((id_src1_vld && id_src1 == ex_dst) || (id_src2_vld && id_src2 == ex_dst));
    endfunction

    // Expected {data_hazard, PC_hazard, pop_haz, flush_ifid, bubble_idex, busy}.
    function automatic logic [5:0] exp_vec();
        bit l;
        l = lu();
        if (rst) return 6'b000000;
        if (flush_left_m > 0) return 6'b010111;
        if (pop_left_m > 0) return pc_redirect ? 6'b000111 : 6'b001011;
        return {l && !pc_redirect, 1'b0, pop_req && !l && !pc_redirect,
                pc_redirect, pc_redirect || l, 1'b0};
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef HAZARD_PERF_CNT_EN
        return 16'(perf_m);
`else
        return 16'h0000;
`endif
    endfunction

    // Model update at each active edge.
    always @(posedge clk) begin
        logic [5:0] e;
        e = exp_vec();
        if (rst) begin
            pop_left_m   <= 0;
            flush_left_m <= 0;
            perf_m       <= 0;
        end else begin
            if (flush_left_m > 0) begin
                flush_left_m <= pc_redirect ? FC : flush_left_m - 1;
            end else if (pop_left_m > 0) begin
                if (pc_redirect) begin
                    flush_left_m <= FC;
                    pop_left_m   <= 0;
                end else begin
                    pop_left_m <= pop_left_m - 1;
                end
            end else if (pc_redirect) begin
                flush_left_m <= FC;
            end else if (pop_req && !lu()) begin
                pop_left_m <= PC - 1;
            end
            if (e[5] || e[4] || e[3]) perf_m <= (perf_m >= 65535) ? 65535 : perf_m + 1;
        end
    end

    task automatic idle_inputs();
        id_src1 = '0; id_src1_vld = 1'b0; id_src2 = '0; id_src2_vld = 1'b0;
        ex_dst = '0; ex_is_load = 1'b0; pc_redirect = 1'b0; pop_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            id_src1 = AW'($urandom_range(0, 3)); id_src1_vld = 1'($urandom);
            ex_dst = id_src1; ex_is_load = 1'b1;
            pc_redirect = 1'($urandom); pop_req = 1'($urandom);
            @(negedge clk);
            total++;
            if (obs !== 6'b000000) begin
                bad++; $display("FAIL reset_outputs c%0d: got %b want 000000", i, obs);
            end
            total++;
            if (stall_cnt !== 16'h0000) begin
                bad++; $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt);
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        total++;
        if (obs !== 6'b000000) begin
            bad++; $display("FAIL reset_release: got %b want 000000", obs);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        settle();
        ex_is_load = 1'b1; ex_dst = 5'd5; id_src2 = 5'd5; id_src2_vld = 1'b1;
        @(negedge clk);
        total++;
        if ({data_hazard, bubble_idex, pop_haz} !== 3'b110) begin
            bad++; $display("FAIL load_use_hit: got dh/bub/pop=%b want 110", {data_hazard, bubble_idex, pop_haz});
        end
        next_cycle();
        idle_inputs();
        ex_is_load = 1'b1; ex_dst = 5'd0; id_src1 = 5'd0; id_src1_vld = 1'b1;
        @(negedge clk);
        total++;
        if ({data_hazard, bubble_idex} !== 2'b00) begin
            bad++; $display("FAIL load_use_r0: got dh/bub=%b want 00", {data_hazard, bubble_idex});
        end
        next_cycle();
        idle_inputs();
        ex_is_load = 1'b0; ex_dst = 5'd7; id_src1 = 5'd7; id_src1_vld = 1'b1;
        @(negedge clk);
        total++;
        if (data_hazard !== 1'b0) begin
            bad++; $display("FAIL load_use_noload: got %b want 0", data_hazard);
        end
        next_cycle();
    endtask

    task automatic test_pop();
        logic [2:0] want_pop;
        logic [2:0] want_busy;
        want_pop  = 3'b011;
        want_busy = 3'b010;
        settle();
        pop_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (pop_haz !== want_pop[i]) begin
                bad++; $display("FAIL pop_haz c%0d: got %b want %b", i, pop_haz, want_pop[i]);
            end
            total++;
            if (busy !== want_busy[i]) begin
                bad++; $display("FAIL pop_busy c%0d: got %b want %b", i, busy, want_busy[i]);
            end
            next_cycle();
            pop_req = 1'b0;
        end
    endtask

    task automatic test_redirect();
        logic [2:0] want_pch;
        logic [2:0] want_fl;
        want_pch = 3'b010;
        want_fl  = 3'b011;
        settle();
        pc_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({PC_hazard, flush_ifid} !== {want_pch[i], want_fl[i]}) begin
                bad++; $display("FAIL redirect c%0d: got pch/fl=%b%b want %b%b",
                                i, PC_hazard, flush_ifid, want_pch[i], want_fl[i]);
            end
            next_cycle();
            pc_redirect = 1'b0;
        end
    endtask

    task automatic test_priority();
        logic [5:0] want [3];
        want[0] = 6'b000110;
        want[1] = 6'b010111;
        want[2] = 6'b000000;
        settle();
        pc_redirect = 1'b1; pop_req = 1'b1;
        ex_is_load = 1'b1; ex_dst = 5'd9; id_src1 = 5'd9; id_src1_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== want[i]) begin
                bad++; $display("FAIL priority c%0d: got %b want %b", i, obs, want[i]);
            end
            next_cycle();
            idle_inputs();
        end
    endtask

    task automatic test_reset_mid_pop();
        settle();
        pop_req = 1'b1;
        next_cycle();
        pop_req = 1'b0;
        @(negedge clk);
        total++;
        if ({pop_haz, busy} !== 2'b11) begin
            bad++; $display("FAIL midpop_pre: got pop/busy=%b want 11", {pop_haz, busy});
        end
        next_cycle();
        rst = 1'b1;
        pop_req = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 6'b000000) begin
            bad++; $display("FAIL midpop_rst: got %b want 000000", obs);
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        total++;
        if ({obs, stall_cnt} !== 22'h0) begin
            bad++; $display("FAIL midpop_after: got obs=%b cnt=%h want 0", obs, stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [5:0] e;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            id_src1     = AW'($urandom_range(0, 3));
            id_src2     = AW'($urandom_range(0, 3));
            ex_dst      = AW'($urandom_range(0, 3));
            id_src1_vld = 1'($urandom);
            id_src2_vld = 1'($urandom);
            ex_is_load  = ($urandom_range(0, 99) < 40);
            pc_redirect = ($urandom_range(0, 99) < 12);
            pop_req     = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            e = exp_vec();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL random_out c%0d: got %b want %b", i, obs, e);
            end
            total++;
            if (stall_cnt !== exp_stall()) begin
                bad++; $display("FAIL random_cnt c%0d: got %h want %h", i, stall_cnt, exp_stall());
            end
            total++;
            if ($countones({data_hazard, pop_haz, PC_hazard}) > 1) begin
                bad++; $display("FAIL random_excl c%0d: got dh/pop/pch=%b want at most one",
                                i, {data_hazard, pop_haz, PC_hazard});
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_saturate();
        int n;
`ifdef HAZARD_PERF_CNT_EN
        n = 70000;
`else
        n = 300;
`endif
        settle();
        ex_is_load = 1'b1; ex_dst = 5'd3; id_src1 = 5'd3; id_src1_vld = 1'b1;
        repeat (n) next_cycle();
        @(negedge clk);
        total++;
        if (stall_cnt !== exp_stall()) begin
            bad++; $display("FAIL saturate: got %h want %h", stall_cnt, exp_stall());
        end
        total++;
        if (data_hazard !== 1'b1) begin
            bad++; $display("FAIL saturate_dh: got %b want 1", data_hazard);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_pop();
        test_redirect();
        test_priority();
        test_reset_mid_pop();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
